universal_shift_register: RTL and testbench
===========================================

# universal_shift_register

Parametrised multi-lane shift register: DEPTH stages, each WIDTH bits. Supports hold, left/right shift, left/right rotate, parallel load and clear, selected per cycle. A frame counter flags when DEPTH shift steps have completed since the last load, clear or reset. Used as the common serializer/deserializer and delay-line primitive in datapaths that previously used a fixed single-bit shift register.

## Interface
- WIDTH, 8, bits per stage; legal range ≥ 1
- DEPTH, 4, number of stages; legal range ≥ 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  operation enable; 0 = hold all state, including the counter
- mode  input  3  operation select (encoding below)
- din  input  WIDTH  serial lane input
- pin  input  DEPTH*WIDTH  parallel load data; stage k = pin[k*WIDTH +: WIDTH]
- pout  output  DEPTH*WIDTH  all stages, same packing as pin
- dout_l  output  WIDTH  stage DEPTH-1 (left end)
- dout_r  output  WIDTH  stage 0 (right end)
- shift_cnt  output  $clog2(DEPTH+1)  shift steps taken in the current frame
- frame_done  output  1  single-cycle pulse; a frame of DEPTH steps has completed

## Operation
- Mode encoding (applies only when en=1):
  - 000 HOLD: no change.
  - 001 SHL: stage[k] ← stage[k-1] for k ≥ 1; stage[0] ← din.
  - 010 SHR: stage[k] ← stage[k+1] for k ≤ DEPTH-2; stage[DEPTH-1] ← din.
  - 011 LOAD: all stages ← pin.
  - 100 ROTL: SHL with stage[0] ← old stage[DEPTH-1]; din ignored.
  - 101 ROTR: SHR with stage[DEPTH-1] ← old stage[0]; din ignored.
  - 110 CLEAR: all stages ← 0.
  - 111 reserved; behaves exactly as HOLD.
- Shift step = SHL, SHR, ROTL or ROTR with en=1.
- Counter:
  - A shift step increments shift_cnt.
  - A step that would make shift_cnt = DEPTH sets it to 0 instead and asserts frame_done on the next cycle.
  - LOAD and CLEAR set shift_cnt to 0 and never pulse frame_done.
  - HOLD, reserved and en=0 leave shift_cnt unchanged.
- Direction changes mid-frame do not reset the counter. Mixing SHL and SHR still counts every step.
- dout_l, dout_r and pout are direct views of the stage registers. There is no combinational path from din, pin or mode to any output.

## Timing
- Reset (rst_n low, asynchronous): all stages 0, pout 0, dout_l 0, dout_r 0, shift_cnt 0, frame_done 0. Asserting reset mid-frame discards the frame. Release is synchronous to clk, and the first operation is taken on the first rising edge with rst_n high.
- Latency: an operation sampled at edge t is visible on pout, dout_l, dout_r and shift_cnt after edge t.
- frame_done is registered: high for exactly the one cycle following the edge that completed the DEPTH-th step.
- Back-to-back frames: continuous shifting gives a frame_done pulse every DEPTH cycles with no bubble.
- Serializer use: LOAD, then DEPTH SHL steps. Stage DEPTH-1 of the loaded word appears on dout_l in the cycle after LOAD, and the remaining stages follow one per step. frame_done coincides with the cycle after the last step.
- Deserializer use: after reset or CLEAR, DEPTH SHL steps. The first din sampled sits in stage DEPTH-1 when frame_done is high.
- en=0 on the same edge as any mode: full hold, with no count and no pulse.

## Structure
- Package shift_reg_pkg holds:
  - typedef enum logic [2:0] shift_mode_e: HOLD, SHL, SHR, LOAD, ROTL, ROTR, CLEAR, RSVD.
  - A function giving the counter width for a given DEPTH.
- Sub-module shift_frame_counter (parameter DEPTH; inputs step and restart; outputs count and done) isolates the counter and done-pulse logic. The stage array and mode mux stay in universal_shift_register.

## Test plan
- Reset: drive stages nonzero, pulse rst_n low asynchronously between edges → all outputs 0 immediately, before the next edge.
- Serialize, WIDTH=8, DEPTH=4: LOAD pin=0x44_33_22_11, then 4×SHL with din=0 → dout_l reads 0x44 after LOAD, then 0x33, 0x22, 0x11, 0x00; frame_done high only in the cycle after the 4th SHL; shift_cnt sequence 0,1,2,3,0.
- Deserialize: after CLEAR, SHR with din=0xA1,0xB2,0xC3,0xD4 → pout=0xD4_C3_B2_A1 and frame_done=1 in the same cycle.
- Rotate: LOAD 0x04_03_02_01, then 4×ROTL → pout returns to 0x04_03_02_01 with one frame_done pulse; ROTR once → 0x01_04_03_02.
- Enable and reserved: SHL with en=0, and mode=111 with en=1 → pout and shift_cnt unchanged, no frame_done.
- Counter restart: 2×SHL, then LOAD, then 4×SHL → exactly one frame_done, after the 4th post-LOAD step; 8 continuous SHL steps → two pulses exactly 4 cycles apart.

Source files
------------

// File: rtl/universal_shift_register_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_pkg
// Shared types and helpers for the universal shift register block.
//   shift_mode_e : per-cycle operation select carried on the mode bus.
//   cnt_width()  : width of the frame step counter for a given DEPTH. The
//                  counter never holds DEPTH itself, but it is sized for
//                  0..DEPTH so that its width matches the shift_cnt port.
// -----------------------------------------------------------------------------
package shift_reg_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'b000,
    SHL   = 3'b001,
    SHR   = 3'b010,
    LOAD  = 3'b011,
    ROTL  = 3'b100,
    ROTR  = 3'b101,
    CLEAR = 3'b110,
    RSVD  = 3'b111
  } shift_mode_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// -----------------------------------------------------------------------------
// universal_shift_register_if
// Groups the control, data and status signals of the universal shift register.
//   en, mode    : operation enable and operation select
//   din         : serial lane input (WIDTH bits)
//   pin         : parallel load data, stage k at [k*WIDTH +: WIDTH]
//   pout        : all stages, same packing as pin
//   dout_l      : stage DEPTH-1 (left end)
//   dout_r      : stage 0 (right end)
//   shift_cnt   : shift steps taken in the current frame
//   frame_done  : one-cycle pulse after the DEPTH-th step of a frame
// master drives control/data (the user), slave is the shift register.
// -----------------------------------------------------------------------------
interface universal_shift_register_if
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);

  localparam int CW = cnt_width(DEPTH);

  logic                   en;
  shift_mode_e            mode;
  logic [WIDTH-1:0]       din;
  logic [DEPTH*WIDTH-1:0] pin;
  logic [DEPTH*WIDTH-1:0] pout;
  logic [WIDTH-1:0]       dout_l;
  logic [WIDTH-1:0]       dout_r;
  logic [CW-1:0]          shift_cnt;
  logic                   frame_done;

  modport master (
    output en, mode, din, pin,
    input  pout, dout_l, dout_r, shift_cnt, frame_done
  );

  modport slave (
    input  en, mode, din, pin,
    output pout, dout_l, dout_r, shift_cnt, frame_done
  );

endinterface

// File: rtl/universal_shift_register_frame_counter.sv
// -----------------------------------------------------------------------------
// shift_frame_counter
// Counts shift steps within a frame of DEPTH steps and pulses done for one
// cycle after the step that completes the frame.
//   clk, rst_n : clock, asynchronous active-low reset
//   step       : a shift step is taken on this edge
//   restart    : LOAD/CLEAR on this edge; zero the count, no pulse
//   count      : steps taken in the current frame (0..DEPTH-1)
//   done       : registered one-cycle frame completion pulse
// -----------------------------------------------------------------------------
module shift_frame_counter
  import shift_reg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic          restart,
  output logic [CW-1:0] count,
  output logic          done
);

  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (restart) begin
        count <= '0;
      end else if (step) begin
        // The DEPTH-th step wraps straight to zero so back-to-back frames
        // pulse every DEPTH cycles with no bubble.
        if (count == LAST) begin
          count <= '0;
          done  <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
// DEPTH stages of WIDTH bits with hold, left/right shift, left/right rotate,
// parallel load and clear selected per cycle, plus a frame step counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : universal_shift_register_if slave (en, mode, din, pin in;
//                pout, dout_l, dout_r, shift_cnt, frame_done out)
// All outputs come straight from registers; there is no combinational path
// from din, pin or mode to any output.
// -----------------------------------------------------------------------------
module universal_shift_register
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  universal_shift_register_if.slave   bus
);

  logic [WIDTH-1:0]       stage      [DEPTH];
  logic [WIDTH-1:0]       stage_next [DEPTH];
  logic [DEPTH*WIDTH-1:0] pout_flat;
  logic                   step;
  logic                   restart;

  // Next-state mux for the stage array.
  // NOTE: every path starts from stage_next = stage so no branch leaves a
  // signal unassigned; that is what keeps this block free of latches.
  always_comb begin
    stage_next = stage;
    if (bus.en) begin
      case (bus.mode)
        SHL: begin
          for (int k = 1; k < DEPTH; k++) stage_next[k] = stage[k-1];
          stage_next[0] = bus.din;
        end
        SHR: begin
          for (int k = 0; k < DEPTH - 1; k++) stage_next[k] = stage[k+1];
          stage_next[DEPTH-1] = bus.din;
        end
        ROTL: begin
          for (int k = 1; k < DEPTH; k++) stage_next[k] = stage[k-1];
          stage_next[0] = stage[DEPTH-1];
        end
        ROTR: begin
          for (int k = 0; k < DEPTH - 1; k++) stage_next[k] = stage[k+1];
          stage_next[DEPTH-1] = stage[0];
        end
        LOAD: begin
          for (int k = 0; k < DEPTH; k++) stage_next[k] = bus.pin[k*WIDTH +: WIDTH];
        end
        CLEAR: begin
          for (int k = 0; k < DEPTH; k++) stage_next[k] = '0;
        end
        default: ; // HOLD and reserved encoding: no change
      endcase
    end
  end

  // NOTE: the stage array is reset even though it is storage, because
  // outputs must read zero during reset and a frame in progress is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else begin
      stage <= stage_next;
    end
  end

  always_comb begin
    pout_flat = '0;
    for (int k = 0; k < DEPTH; k++) pout_flat[k*WIDTH +: WIDTH] = stage[k];
  end

  assign bus.pout   = pout_flat;
  assign bus.dout_l = stage[DEPTH-1];
  assign bus.dout_r = stage[0];

  assign step    = bus.en && (bus.mode inside {SHL, SHR, ROTL, ROTR});
  assign restart = bus.en && (bus.mode inside {LOAD, CLEAR});

  shift_frame_counter #(
    .DEPTH (DEPTH)
  ) u_frame_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .step    (step),
    .restart (restart),
    .count   (bus.shift_cnt),
    .done    (bus.frame_done)
  );

endmodule

// File: tb/tb_universal_shift_register.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_register
// Directed bench for universal_shift_register at WIDTH=8, DEPTH=4. Inputs are
// driven 1 ns after the rising edge and outputs are sampled at the same point,
// so every operation is seen exactly one edge after it is applied.
// -----------------------------------------------------------------------------
module tb_universal_shift_register;
  import shift_reg_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;
  int   pulses;
  int   first_pulse;
  int   second_pulse;

  universal_shift_register_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  universal_shift_register #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input logic e, input shift_mode_e m,
                      input logic [7:0] d, input logic [31:0] p);
    bus.en   = e;
    bus.mode = m;
    bus.din  = d;
    bus.pin  = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests    = 0;
    failed   = 0;
    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.mode = HOLD;
    bus.din  = '0;
    bus.pin  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pout", 64'(bus.pout), 64'h0);
    check("rst_cnt", 64'(bus.shift_cnt), 64'h0);
    check("rst_fd", 64'(bus.frame_done), 64'h0);
    rst_n = 1'b1;

    // Asynchronous reset between edges, mid-frame
    step(1'b1, LOAD, 8'h00, 32'hDEAD_BEEF);
    check("pre_rst_pout", 64'(bus.pout), 64'hDEAD_BEEF);
    step(1'b1, SHL, 8'h5A, 32'h0);
    check("pre_rst_cnt", 64'(bus.shift_cnt), 64'h1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_pout", 64'(bus.pout), 64'h0);
    check("async_rst_dl", 64'(bus.dout_l), 64'h0);
    check("async_rst_dr", 64'(bus.dout_r), 64'h0);
    check("async_rst_cnt", 64'(bus.shift_cnt), 64'h0);
    check("async_rst_fd", 64'(bus.frame_done), 64'h0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Serializer: LOAD then 4x SHL with din=0
    step(1'b1, LOAD, 8'h00, 32'h4433_2211);
    check("ser_load_dl", 64'(bus.dout_l), 64'h44);
    check("ser_load_dr", 64'(bus.dout_r), 64'h11);
    check("ser_load_cnt", 64'(bus.shift_cnt), 64'h0);
    check("ser_load_fd", 64'(bus.frame_done), 64'h0);
    step(1'b1, SHL, 8'h00, 32'h0);
    check("ser1_dl", 64'(bus.dout_l), 64'h33);
    check("ser1_cnt", 64'(bus.shift_cnt), 64'h1);
    check("ser1_fd", 64'(bus.frame_done), 64'h0);
    step(1'b1, SHL, 8'h00, 32'h0);
    check("ser2_dl", 64'(bus.dout_l), 64'h22);
    check("ser2_cnt", 64'(bus.shift_cnt), 64'h2);
    check("ser2_fd", 64'(bus.frame_done), 64'h0);
    step(1'b1, SHL, 8'h00, 32'h0);
    check("ser3_dl", 64'(bus.dout_l), 64'h11);
    check("ser3_cnt", 64'(bus.shift_cnt), 64'h3);
    check("ser3_fd", 64'(bus.frame_done), 64'h0);
    step(1'b1, SHL, 8'h00, 32'h0);
    check("ser4_dl", 64'(bus.dout_l), 64'h00);
    check("ser4_cnt", 64'(bus.shift_cnt), 64'h0);
    check("ser4_fd", 64'(bus.frame_done), 64'h1);
    step(1'b1, HOLD, 8'h00, 32'h0);
    check("ser_fd_single", 64'(bus.frame_done), 64'h0);

    // Deserializer: CLEAR then SHR with A1, B2, C3, D4
    step(1'b1, CLEAR, 8'h00, 32'h0);
    check("des_clear_pout", 64'(bus.pout), 64'h0);
    step(1'b1, SHR, 8'hA1, 32'h0);
    check("des1_pout", 64'(bus.pout), 64'hA100_0000);
    step(1'b1, SHR, 8'hB2, 32'h0);
    step(1'b1, SHR, 8'hC3, 32'h0);
    check("des3_fd", 64'(bus.frame_done), 64'h0);
    step(1'b1, SHR, 8'hD4, 32'h0);
    check("des4_pout", 64'(bus.pout), 64'hD4C3_B2A1);
    check("des4_fd", 64'(bus.frame_done), 64'h1);

    // Rotate: LOAD then 4x ROTL returns the word, one pulse; then ROTR once
    step(1'b1, LOAD, 8'h00, 32'h0403_0201);
    pulses = 0;
    step(1'b1, ROTL, 8'hFF, 32'h0);
    check("rotl1_pout", 64'(bus.pout), 64'h0302_0104);
    pulses += int'(bus.frame_done);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ROTL, 8'hFF, 32'h0);
      pulses += int'(bus.frame_done);
    end
    check("rotl4_pout", 64'(bus.pout), 64'h0403_0201);
    check("rotl4_fd", 64'(bus.frame_done), 64'h1);
    check("rotl_pulses", 64'(pulses), 64'h1);
    step(1'b1, ROTR, 8'hFF, 32'h0);
    check("rotr_pout", 64'(bus.pout), 64'h0104_0302);
    check("rotr_cnt", 64'(bus.shift_cnt), 64'h1);
    check("rotr_fd", 64'(bus.frame_done), 64'h0);

    // Enable low and reserved encoding hold everything
    step(1'b0, SHL, 8'hFF, 32'h0);
    check("en0_pout", 64'(bus.pout), 64'h0104_0302);
    check("en0_cnt", 64'(bus.shift_cnt), 64'h1);
    check("en0_fd", 64'(bus.frame_done), 64'h0);
    step(1'b0, LOAD, 8'hFF, 32'hFFFF_FFFF);
    check("en0_load_pout", 64'(bus.pout), 64'h0104_0302);
    step(1'b1, RSVD, 8'hFF, 32'hFFFF_FFFF);
    check("rsvd_pout", 64'(bus.pout), 64'h0104_0302);
    check("rsvd_cnt", 64'(bus.shift_cnt), 64'h1);
    check("rsvd_fd", 64'(bus.frame_done), 64'h0);

    // Counter restart: 2x SHL, LOAD, 4x SHL gives one pulse after 4th step
    step(1'b1, SHL, 8'h01, 32'h0);
    step(1'b1, SHL, 8'h02, 32'h0);
    check("rs_pre_cnt", 64'(bus.shift_cnt), 64'h3);
    step(1'b1, LOAD, 8'h00, 32'h0);
    check("rs_load_cnt", 64'(bus.shift_cnt), 64'h0);
    check("rs_load_fd", 64'(bus.frame_done), 64'h0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, SHL, 8'h00, 32'h0);
      pulses += int'(bus.frame_done);
    end
    check("rs_early_pulses", 64'(pulses), 64'h0);
    step(1'b1, SHL, 8'h00, 32'h0);
    check("rs_4th_fd", 64'(bus.frame_done), 64'h1);

    // Eight continuous steps: pulses after steps 4 and 8, four cycles apart
    pulses       = 0;
    first_pulse  = -1;
    second_pulse = -1;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, SHL, 8'(i), 32'h0);
      if (bus.frame_done === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
        else second_pulse = i;
      end
    end
    check("cont_pulses", 64'(pulses), 64'h2);
    check("cont_first", 64'(first_pulse), 64'h4);
    check("cont_gap", 64'(second_pulse - first_pulse), 64'h4);

    // Mixed directions still count every step
    step(1'b1, SHL, 8'h00, 32'h0);
    step(1'b1, SHR, 8'h00, 32'h0);
    step(1'b1, SHL, 8'h00, 32'h0);
    check("mix3_cnt", 64'(bus.shift_cnt), 64'h3);
    step(1'b1, SHR, 8'h00, 32'h0);
    check("mix4_fd", 64'(bus.frame_done), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
